audio_i2s_tx: RTL and testbench

Serializes the 24-bit audio sample word written by the NIOS II into the audio sample-out PIO (`out_port`) into a Philips I2S stream for the board codec DAC (WM8731 in slave mode). The block generates BCLK and DACLRCK from the system clock, latches the sample once per frame, and sends it MSB-first on both channels (mono). A frame-start strobe lets software or a downstream interrupt pace sample writes.

---
 rtl/audio_i2s_tx.sv | 72 +++++++
 tb/tb_audio_i2s_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: Philips I2S mono serializer for the WM8731 DAC, one 24-bit sample latched per frame
module audio_i2s_tx #(
    parameter int BCLK_DIV  = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [23:0] sample_in,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic        sample_tick
);
    localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT = BW'(SLOT_BITS);
    localparam logic [BW-1:0] WORD = BW'(24);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt, nxt_bit, pos;
    logic [23:0]   hold;
    logic [4:0]    idx;
    logic          bclk, lrck, dat, tick, div_wrap, fe, in_word;

    always_comb begin
        div_wrap = div_cnt == DIV_LAST;
        fe = div_wrap && bclk;
        nxt_bit = bit_cnt == BIT_LAST ? '0 : bit_cnt + BW'(1);
        pos = nxt_bit >= SLOT ? nxt_bit - SLOT : nxt_bit;
        in_word = pos != '0 && pos <= WORD;
        idx = in_word ? 5'(WORD - pos) : 5'd0;
    end

    // Data and word select move only on bclk falling edges so they are stable around each rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk <= 1'b0;
            bit_cnt <= BIT_LAST;
            lrck <= 1'b1;
            dat <= 1'b0;
            hold <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bclk <= 1'b0;
            bit_cnt <= BIT_LAST;
            lrck <= 1'b1;
            dat <= 1'b0;
            hold <= '0;
            tick <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
            bclk <= bclk ^ div_wrap;
            tick <= fe && nxt_bit == '0;
            if (fe) begin
                bit_cnt <= nxt_bit;
                lrck <= nxt_bit >= SLOT;
                dat <= in_word && hold[idx];
                if (nxt_bit == '0) hold <= sample_in;
            end
        end
    end

    assign aud_bclk = bclk;
    assign aud_daclrck = lrck;
    assign aud_dacdat = dat;
    assign sample_tick = tick;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed scoreboard bench for audio_i2s_tx at default and minimum parameters
module tb_audio_i2s_tx;
    logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b1, en2 = 1'b1;
    logic [23:0] sample_in = 24'hA5F00F, s2 = 24'h000001;
    logic        aud_bclk, aud_daclrck, aud_dacdat, sample_tick, b2, l2, d2, t2;
    int          errors = 0, checks = 0;
    logic        q1[$], q2[$];

    always #5 clk = ~clk;

    audio_i2s_tx dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
        .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat), .sample_tick(sample_tick)
    );

    audio_i2s_tx #(.BCLK_DIV(1), .SLOT_BITS(25)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(en2), .sample_in(s2),
        .aud_bclk(b2), .aud_daclrck(l2), .aud_dacdat(d2), .sample_tick(t2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic slot_bit(input logic [23:0] v, input int p);
        return (p >= 1 && p <= 24) ? v[24 - p] : 1'b0;
    endfunction

    task automatic push1(input logic [23:0] v);
        for (int k = 0; k < 64; k++) q1.push_back(slot_bit(v, k % 32));
    endtask

    task automatic push2(input logic [23:0] v);
        for (int k = 0; k < 50; k++) q2.push_back(slot_bit(v, k % 25));
    endtask

    // Codec-side monitors: sample data on each bit-clock rise and compare with the scoreboard.
    initial forever begin
        @(posedge aud_bclk);
        #1;
        if (q1.size() > 0) check("dat", int'(aud_dacdat), int'(q1.pop_front()));
    end

    initial forever begin
        @(posedge b2);
        #1;
        if (q2.size() > 0) check("dat2", int'(d2), int'(q2.pop_front()));
    end

    task automatic wait_tick(input string name);
        int n, r;
        n = 0;
        r = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (aud_bclk && r == 0) r = i;
            if (sample_tick) begin
                n = i;
                push1(sample_in);
                break;
            end
        end
        check({name, "_tick"}, n, 16);
        check({name, "_rise"}, r, 8);
        check({name, "_lrck_bclk"}, int'({aud_daclrck, aud_bclk}), 0);
    endtask

    task automatic run_frame(input int chg_at, input logic [23:0] chg_val, input int stop_at);
        logic pb;
        int   ticks, tick_at, lr_hi, tog, r0, r1;
        pb = aud_bclk;
        ticks = 0;
        tick_at = 0;
        lr_hi = 0;
        tog = 0;
        r0 = 0;
        r1 = 0;
        for (int i = 1; i <= 1024; i++) begin
            @(posedge clk);
            #1;
            if (sample_tick) begin
                ticks++;
                tick_at = i;
                push1(sample_in);
            end
            if (i == chg_at) sample_in = chg_val;
            if (aud_daclrck) lr_hi++;
            if (aud_bclk != pb) begin
                tog++;
                if (aud_bclk && r0 == 0) r0 = i;
                else if (aud_bclk && r1 == 0) r1 = i;
            end
            pb = aud_bclk;
            if (i == stop_at) return;
        end
        check("tick_at", tick_at, 1024);
        check("ticks_per_frame", ticks, 1);
        check("lrck_high_clks", lr_hi, 512);
        check("bclk_toggles", tog, 128);
        check("bclk_first_rise", r0, 8);
        check("bclk_period", r1 - r0, 16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'({aud_bclk, aud_daclrck, aud_dacdat, sample_tick}), 4);
        reset_n = 1'b1;
        wait_tick("startup");
        run_frame(500, 24'h7FFFFF, 0);
        run_frame(300, 24'h800000, 0);
        run_frame(0, 24'h0, 700);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("enable_low_state", int'({aud_bclk, aud_daclrck, aud_dacdat, sample_tick}), 4);
        q1.delete();
        sample_in = 24'h5A5A5A;
        repeat (4) @(posedge clk);
        #1;
        check("enable_low_hold", int'({aud_bclk, aud_daclrck, aud_dacdat, sample_tick}), 4);
        enable = 1'b1;
        wait_tick("reenable");
        run_frame(0, 24'h0, 0);
        run_frame(0, 24'h0, 40);
        check("pre_reset", int'({aud_bclk, aud_daclrck, aud_dacdat}), 5);
        #3 reset_n = 1'b0;
        #1 check("async_reset", int'({aud_bclk, aud_daclrck, aud_dacdat, sample_tick}), 4);
        q1.delete();
        @(posedge clk);
        #1;
        check("corner_reset_state", int'({b2, l2, d2, t2}), 4);
        reset_n = 1'b1;
        begin : corner
            logic pb;
            int   ticks, first, last, tog;
            pb = b2;
            ticks = 0;
            first = 0;
            last = 0;
            tog = 0;
            for (int i = 1; i <= 250; i++) begin
                @(posedge clk);
                #1;
                if (b2 != pb) tog++;
                pb = b2;
                if (t2) begin
                    ticks++;
                    if (ticks == 1) first = i;
                    else check("corner_frame_len", i - last, 100);
                    last = i;
                    push2(s2);
                end
            end
            check("corner_first_tick", first, 2);
            check("corner_ticks", ticks, 3);
            check("corner_bclk_toggles", tog, 250);
        end
        for (int i = 0; i < 300 && (q1.size() + q2.size()) > 0; i++) @(posedge clk);
        check("scoreboard_drain", q1.size() + q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
